load_mem_ctrl: RTL

- Sequences every load instruction over a single-beat AXI4 read channel.
- Stalls the single-cycle core until the data returns, extracts the addressed byte lanes, and sign/zero-extends them per funct3.
- Sits between the core's execute stage (address + instruction) and the AXI4 read interconnect.
- Replaces direct combinational memory reads for loads.

---
 rtl/load_mem_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/load_mem_ctrl.sv
// load_mem_ctrl: runs each RV64 load as one single-beat AXI4 read, stalls the core
// while it is in flight and returns the lane-extracted, sign/zero-extended result.
module load_mem_ctrl #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [31:0]       instr,
   input  logic [ADDR_W-1:0] addr,
   output logic              stall,
   output logic              load_done,
   output logic [DATA_W-1:0] load_data,
   output logic              load_err,
   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arsize,
   output logic [7:0]        arlen,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2, DONE = 2'd3} state_t;
   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   state_t            state_r;
   state_t            state_nx_s;
   logic [ADDR_W-1:0] addr_r;
   logic [2:0]        funct3_r;
   logic [DATA_W-1:0] data_r;
   logic              err_r;
   logic              accept_s;
   logic              bad_s;
   logic              unused_s;

   // funct3[1:0] is log2 of the access size; natural alignment is required
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lsb);
      case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = lsb[0];
         2'd2:    misaligned = |lsb[1:0];
         2'd3:    misaligned = |lsb;
         default: misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3,
                                                input logic [DATA_W-1:0] d,
                                                input logic [2:0] lane);
      logic [DATA_W-1:0] sh;
      sh = d >> {lane, 3'b000};
      case (f3)
         3'b000:  extend = {{(DATA_W-8){sh[7]}}, sh[7:0]};
         3'b001:  extend = {{(DATA_W-16){sh[15]}}, sh[15:0]};
         3'b010:  extend = {{(DATA_W-32){sh[31]}}, sh[31:0]};
         3'b011:  extend = sh;
         3'b100:  extend = {{(DATA_W-8){1'b0}}, sh[7:0]};
         3'b101:  extend = {{(DATA_W-16){1'b0}}, sh[15:0]};
         3'b110:  extend = {{(DATA_W-32){1'b0}}, sh[31:0]};
         default: extend = {DATA_W{1'b0}};
      endcase
   endfunction

   assign accept_s = (state_r == IDLE) && load_valid;
   assign bad_s    = (instr[6:0] != OPC_LOAD) || (instr[14:12] == 3'b111) ||
                     misaligned(instr[13:12], addr[2:0]);
   assign unused_s = ^{rlast, instr[31:15], instr[11:7]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; illegal or misaligned loads skip the bus entirely
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (load_valid) begin
               state_nx_s = bad_s ? DONE : AR;
            end else begin
               state_nx_s = IDLE;
            end
         end
         AR: begin
            if (arready) begin
               state_nx_s = R;
            end else begin
               state_nx_s = AR;
            end
         end
         R: begin
            if (rvalid) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = R;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Captured request and result; the result clears on capture and holds past DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r   <= {ADDR_W{1'b0}};
         funct3_r <= 3'b000;
         data_r   <= {DATA_W{1'b0}};
         err_r    <= 1'b0;
      end else if (accept_s) begin
         addr_r   <= addr;
         funct3_r <= instr[14:12];
         data_r   <= {DATA_W{1'b0}};
         err_r    <= bad_s;
      end else if ((state_r == R) && rvalid) begin
         if (rresp != 2'b00) begin
            data_r <= {DATA_W{1'b0}};
            err_r  <= 1'b1;
         end else begin
            data_r <= extend(funct3_r, rdata, addr_r[2:0]);
            err_r  <= 1'b0;
         end
      end else begin
         data_r <= data_r;
         err_r  <= err_r;
      end
   end

   // Output decode from the state register; stall is forced low during reset
   always_comb begin
      arvalid   = (state_r == AR);
      rready    = (state_r == R);
      load_done = (state_r == DONE);
      stall     = !rst && (accept_s || (state_r == AR) || (state_r == R));
      araddr    = addr_r;
      arsize    = {1'b0, funct3_r[1:0]};
      arlen     = 8'd0;
      arburst   = 2'b01;
      load_data = data_r;
      load_err  = err_r;
   end

endmodule
